// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table, digit-vector type and shared constants for the seven-segment driver.
package seg7_pkg;

    typedef logic [7:0][3:0] bcd8_t;

    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [31:0] DEC_LIMIT = 32'd100000000;

    // Active-low {g,f,e,d,c,b,a}; entry 15 is listed first.
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] d);
        return GLYPH[d];
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// bin2bcd: iterative double-dabble converter, one shift/add-3 step per cycle over 32 cycles.
module bin2bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        done,
    output logic [39:0] bcd
);
    logic [31:0] sr;
    logic [5:0]  cnt;
    logic [39:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 10; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= !start && cnt == 6'd1;
            if (start) begin
                sr  <= bin;
                bcd <= '0;
                cnt <= 6'd32;
            end else if (cnt != 6'd0) begin
                {bcd, sr} <= {adj, sr} << 1;
                cnt       <= cnt - 6'd1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: eight-digit multiplexed common-anode driver rendering a 32-bit word in hex or
// unsigned decimal, with optional leading-zero blanking and a decimal overflow marker.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        dec_mode,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);
    localparam int            DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_q;
    logic [2:0]    idx;
    logic [31:0]   val_q;
    logic          mode_q;
    logic          first_q;
    logic          accept;
    logic          conv_done;
    logic          ovf;
    logic          zero_above;
    logic [39:0]   bcd;
    logic [7:0]    blank;
    bcd8_t         dig_q;

    assign accept = !busy && (first_q || value != val_q || dec_mode != mode_q);
    assign ovf    = mode_q && val_q >= DEC_LIMIT;

    bin2bcd u_bin2bcd (
        .clk  (clk),
        .rst  (rst),
        .start(accept && dec_mode),
        .bin  (value),
        .done (conv_done),
        .bcd  (bcd)
    );

    // A decimal accept leaves the old digits up until the converter reports done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_q <= 1'b1;
            val_q   <= '0;
            mode_q  <= 1'b0;
            busy    <= 1'b0;
            dig_q   <= '0;
        end else begin
            first_q <= 1'b0;
            if (accept) begin
                val_q  <= value;
                mode_q <= dec_mode;
                busy   <= dec_mode;
                if (!dec_mode)
                    dig_q <= value;
            end else if (conv_done) begin
                busy  <= 1'b0;
                dig_q <= bcd[31:0];
            end
        end
    end

    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        for (int i = 7; i >= 1; i--) begin
            zero_above = zero_above && dig_q[i] == 4'd0;
            blank[i]   = blank_lz && zero_above;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            idx   <= '0;
            an    <= 8'hFF;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
        end else begin
            div_q <= div_q == DIV_LAST ? '0 : div_q + DW'(1);
            if (div_q == DIV_LAST)
                idx <= idx + 3'd1;
            an  <= blank[idx] ? 8'hFF : ~(8'd1 << idx);
            seg <= blank[idx] ? SEG_BLANK : hex2seg(dig_q[idx]);
            dp  <= !(ovf && idx == 3'd7);
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed stimulus with a cycle-level display model plus literal frame checks.
module tb_seg7_scan;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .value(value), .dec_mode(dec_mode), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp_v);
        end
    endtask

    // Model: scan position from elapsed cycles, 33-cycle conversion countdown, digits by arithmetic.
    logic [31:0] m_val, m_v;
    logic        m_mode, m_first;
    int          m_left, m_t, m_ix;
    int          m_dig [8];
    bit          m_zero;
    bit   [7:0]  m_blk;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_busy;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_val = '0; m_mode = 0; m_first = 1; m_left = 0; m_t = 0;
            for (int i = 0; i < 8; i++) m_dig[i] = 0;
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_busy = 1'b0;
        end else begin
            m_ix = (m_t / SD) % 8;
            m_zero = 1; m_blk = '0;
            for (int i = 7; i >= 1; i--) begin
                m_zero = m_zero && m_dig[i] == 0;
                m_blk[i] = blank_lz && m_zero;
            end
            exp_an  = m_blk[m_ix] ? 8'hFF : ~(8'h01 << m_ix);
            exp_seg = m_blk[m_ix] ? 7'h7F : gl[m_dig[m_ix]];
            exp_dp  = !(m_mode && m_val >= 32'd100000000 && m_ix == 7);
            m_t++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_v = m_val;
                    for (int i = 0; i < 8; i++) begin
                        m_dig[i] = int'(m_v % 10);
                        m_v = m_v / 10;
                    end
                end
            end else if (m_first || value != m_val || dec_mode != m_mode) begin
                m_val = value;
                m_mode = dec_mode;
                if (dec_mode) m_left = 33;
                else for (int i = 0; i < 8; i++) m_dig[i] = int'((value >> (4 * i)) & 32'hF);
            end
            m_first = 0;
            exp_busy = m_left > 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("an", {24'h0, an}, {24'h0, exp_an});
            chk("seg", {25'h0, seg}, {25'h0, exp_seg});
            chk("dp", {31'h0, dp}, {31'h0, exp_dp});
            chk("busy", {31'h0, busy}, {31'h0, exp_busy});
        end
    end

    logic [6:0] slot [8];
    logic       slot_dp [8];
    logic [7:0] seen;
    int         ff_n;
    logic       busy_seen;

    task automatic capture();
        seen = '0; ff_n = 0; busy_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            busy_seen = busy_seen | busy;
            if (an == 8'hFF) ff_n++;
            for (int i = 0; i < 8; i++)
                if (an == ~(8'h01 << i)) begin
                    seen[i] = 1'b1;
                    slot[i] = seg;
                    slot_dp[i] = dp;
                end
        end
    endtask

    task automatic chk_slots(input string nm, input logic [55:0] g, input logic [7:0] dpv);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_seg%0d", nm, i), {25'h0, slot[i]}, {25'h0, g[7*i +: 7]});
            chk($sformatf("%s_dp%0d", nm, i), {31'h0, slot_dp[i]}, {31'h0, dpv[i]});
        end
    endtask

    task automatic wait_busy(input logic lvl, input string nm);
        int n = 0;
        while (busy !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'h0, busy}, {31'h0, lvl});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt;
        logic [6:0] s7;
        value = 32'h12345678; dec_mode = 1'b1; blank_lz = 1'b1;
        #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_an", {24'h0, an}, 32'hFF);
        chk("rst_seg", {25'h0, seg}, 32'h7F);
        chk("rst_dp", {31'h0, dp}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        value = '0; dec_mode = 1'b0; blank_lz = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rel_an", {24'h0, an}, 32'hFE);
        chk("rel_seg", {25'h0, seg}, 32'h40);

        value = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        capture();
        chk("hex_busy_never", {31'h0, busy_seen}, 32'h0);
        chk_slots("hex", {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}, 8'hFF);

        value = 32'd12345678; dec_mode = 1'b1;
        n = 0; cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) cnt++;
        end while ((busy || cnt == 0) && n < 100);
        chk("busy_len", cnt, 33);
        repeat (2) @(negedge clk);
        capture();
        chk_slots("dec", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 8'hFF);

        value = 32'hFFFFFFFF;
        wait_busy(1'b1, "ovf_busy_up");
        wait_busy(1'b0, "ovf_busy_down");
        repeat (2) @(negedge clk);
        capture();
        chk_slots("ovf", {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12}, 8'h7F);

        value = 32'hA5; dec_mode = 1'b0; blank_lz = 1'b1;
        repeat (2) @(negedge clk);
        capture();
        chk("blk_seen", {24'h0, seen}, 32'h03);
        chk("blk_ff", {31'h0, ff_n > 0}, 32'h1);
        chk("blk_seg0", {25'h0, slot[0]}, 32'h12);
        chk("blk_seg1", {25'h0, slot[1]}, 32'h08);
        value = '0;
        repeat (2) @(negedge clk);
        capture();
        chk("blk0_seen", {24'h0, seen}, 32'h01);
        chk("blk0_seg0", {25'h0, slot[0]}, 32'h40);

        value = 32'd7; dec_mode = 1'b1; blank_lz = 1'b0;
        wait_busy(1'b1, "col_busy_up");
        repeat (9) @(negedge clk);
        value = 32'd99;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("col_idle", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("col_reaccept", {31'h0, busy}, 32'h1);
        s7 = 7'h7F; n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (an == 8'hFE && busy) s7 = seg;
        end
        chk("col_99_done", {31'h0, busy}, 32'h0);
        chk("col_7_shown", {25'h0, s7}, 32'h78);
        repeat (2) @(negedge clk);
        capture();
        chk_slots("col99", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10, 7'h10}, 8'hFF);

        value = 32'd12345;
        wait_busy(1'b1, "abort_busy_up");
        repeat (9) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_an", {24'h0, an}, 32'hFF);
        chk("abort_seg", {25'h0, seg}, 32'h7F);
        chk("abort_dp", {31'h0, dp}, 32'h1);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rerel_an", {24'h0, an}, 32'hFE);
        chk("rerel_seg", {25'h0, seg}, 32'h40);
        chk("rerel_busy", {31'h0, busy}, 32'h1);
        wait_busy(1'b0, "rerel_busy_down");
        repeat (2) @(negedge clk);
        capture();
        chk_slots("rerel", {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 8'hFF);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
